hex_pattern_sequencer: RTL and testbench
========================================

Name: hex_pattern_sequencer

Overview:
Drives NUM_DIGITS seven-segment displays from a bank of NUM_PATTERNS stored hex-digit patterns (e.g. dates, IDs). The displayed pattern is selected by debounced push-buttons (next/previous) or rotates automatically after a programmable dwell time. Sits between the board KEY/SW inputs and the HEX outputs; contains its own ms timebase, debouncers, index FSM and registered 4-to-7 decode.

Parameters:
NUM_DIGITS, 6, displays driven; each digit is a 4-bit code 0x0-0xF.
NUM_PATTERNS, 4, stored patterns; must be >= 2.
CLK_HZ, 50000000, CLK frequency; must be a multiple of 1000.
DWELL_MS, 2000, auto-mode time per pattern in ms; must be >= 1.
DEBOUNCE_MS, 10, key stable time in ms before the debounced state changes; must be >= 1.
LZ_BLANK, 0, 1 = blank leading zero digits.

Ports:
CLK  in  1  system clock.
RST  in  1  reset, asynchronous, active-high.
KEY  in  2  active-low push-buttons: KEY[0] = next, KEY[1] = previous.
MODE  in  1  0 = manual, 1 = auto-rotate.
PATTERNS  in  NUM_PATTERNS*NUM_DIGITS*4  pattern p at [p*NUM_DIGITS*4 +: NUM_DIGITS*4]; digit d of a pattern at [d*4 +: 4], d=0 is rightmost.
HEX  out  NUM_DIGITS*8  active-low segments; digit d at [d*8 +: 8], bit order {DP,g,f,e,d,c,b,a}.
PAT_IDX  out  max(1,clog2(NUM_PATTERNS))  currently selected pattern.

Behaviour:
- Reset values (async, on RST high): PAT_IDX=0, all HEX bytes 8'hFF (blank), tick/dwell/debounce counters 0, debounced keys = released (1), synchronisers = 1.
- Timebase: counter 0..CLK_HZ/1000-1; 1-cycle tick on wrap. For CLK_HZ=1000 the tick is asserted every cycle.
- Keys: each KEY bit goes through a 2-flop synchroniser. Debounced state updates only after the synchronised value differs from it for DEBOUNCE_MS consecutive ticks. Any bounce restarts that count.
- Press event: 1-cycle pulse on a debounced 1->0 transition. Release generates nothing. Holding a key gives exactly one event; no auto-repeat.
- A key held low through reset generates one press event DEBOUNCE_MS after RST falls.
- Index FSM (states MANUAL, AUTO; state = MODE sampled each cycle):
  - next event: idx -> idx+1; NUM_PATTERNS-1 wraps to 0.
  - prev event: idx -> idx-1; 0 wraps to NUM_PATTERNS-1.
  - next and prev events in the same cycle: no change, dwell not restarted.
  - AUTO: dwell counter increments on each tick. When it reaches DWELL_MS-1 on a tick, idx advances (next) and the counter clears.
  - Any key event in AUTO clears the dwell counter. Dwell expiry and key event in the same cycle: the key event wins and is applied once.
  - MANUAL: dwell counter held at 0. A MANUAL->AUTO transition starts a full dwell period.
- Output path: HEX is registered from the current PAT_IDX and PATTERNS, so it updates 1 cycle after a PAT_IDX change or a PATTERNS change. First valid display is on the first CLK edge after RST falls.
- Decode, active-low with DP always 1:
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
  - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
- LZ_BLANK=1: scanning from digit NUM_DIGITS-1 downward, every 0 digit before the first nonzero digit shows 8'hFF. Digit 0 is never blanked, so an all-zero pattern shows a single "0".

Test Plan:
Common bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4, DWELL_MS=8, NUM_PATTERNS=2, NUM_DIGITS=6. Pattern 0 = 0x030200, pattern 1 = 0x080700.

1. Reset: hold RST 3 cycles -> HEX all 8'hFF, PAT_IDX=0. Release RST -> next edge HEX = {C0,B0,C0,A4,C0,C0}.
2. Manual next with bounce: MODE=0; KEY[0] glitches low 2 cycles, then low steady. Required:
   - glitch -> no change;
   - steady low -> PAT_IDX=1 four ticks after the steady low, HEX = {C0,80,C0,F8,C0,C0} one cycle later;
   - holding 20 more cycles -> still 1;
   - release then press KEY[1] -> PAT_IDX=0.
   - wrap check, from idx 0: press KEY[1] -> PAT_IDX=1; press KEY[0] -> PAT_IDX=0.
3. Simultaneous keys: KEY=2'b00 from idx 0, stable -> PAT_IDX stays 0, no HEX change.
4. Auto rotate: MODE=1 at idx 0 -> PAT_IDX=1 after 8 ticks, back to 0 after 16. A KEY[0] press event at tick 5 -> idx 1 immediately, next auto advance 8 ticks after the event.
5. Leading-zero blanking: LZ_BLANK=1, pattern 0x000042 -> HEX = {FF,FF,FF,FF,99,A4}; pattern 0 -> only digit 0 shows C0.
6. Reset mid-operation: assert RST during AUTO at idx 1 with KEY[0] held low -> immediate HEX 8'hFF, PAT_IDX=0. After RST falls with KEY[0] still held -> exactly one advance to idx 1 at 4 ticks.

Source files
------------

// File: rtl/hex_pattern_sequencer.sv
// hex_pattern_sequencer: selects one of NUM_PATTERNS stored hex-digit patterns and
// drives NUM_DIGITS active-low seven-segment displays from it.
// The pattern is stepped by debounced push-buttons or rotates automatically after a dwell time.
// Ports:
//   CLK      - system clock
//   RST      - asynchronous active-high reset
//   KEY      - active-low buttons, [0] = next pattern, [1] = previous pattern
//   MODE     - 0 = manual stepping, 1 = auto-rotate
//   PATTERNS - pattern p at [p*NUM_DIGITS*4 +: NUM_DIGITS*4], digit d at [d*4 +: 4] (d=0 rightmost)
//   HEX      - registered segments, digit d at [d*8 +: 8], bits {DP,g,f,e,d,c,b,a}, active-low
//   PAT_IDX  - currently selected pattern index
module hex_pattern_sequencer #(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned DWELL_MS     = 2000,
    parameter int unsigned DEBOUNCE_MS  = 10,
    parameter bit          LZ_BLANK     = 1'b0,
    localparam int unsigned IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [1:0]                           KEY,
    input  logic                                 MODE,
    input  logic [NUM_PATTERNS*NUM_DIGITS*4-1:0] PATTERNS,
    output logic [NUM_DIGITS*8-1:0]              HEX,
    output logic [IDX_W-1:0]                     PAT_IDX
);

    localparam int unsigned PAT_W    = NUM_DIGITS * 4;
    localparam int unsigned TICK_DIV = CLK_HZ / 1000;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DWELL_W  = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int unsigned DB_W     = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DWELL_W-1:0]       dwell_q, dwell_d;
    logic [TICK_W-1:0]        tick_cnt_q, tick_cnt_d;
    logic [1:0]               sync1_q, sync2_q;
    logic [1:0]               db_q, db_d;
    logic [1:0][DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [NUM_DIGITS*8-1:0]  hex_q, hex_d;

    logic                     tick_c;
    logic [1:0]               press_c;
    logic                     next_ev_c, prev_ev_c;
    logic [IDX_W-1:0]         idx_inc_c, idx_dec_c;
    logic [PAT_W-1:0]         pat_sel_c;
    logic [3:0]               digit_c;
    logic                     lead_c;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;
            4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;
            4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;
            4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;
            4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
        endcase
    endfunction

    // Millisecond timebase: single-cycle tick on counter wrap (every cycle when TICK_DIV = 1)
    always_comb begin
        tick_c     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // Debounce: state follows the synchronised key after DEBOUNCE_MS consecutive differing ticks
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        press_c  = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == db_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (tick_c) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_MS - 1)) begin
                    db_d[k]     = sync2_q[k];
                    db_cnt_d[k] = '0;
                    press_c[k]  = ~sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    // Simultaneous next+prev cancel out and are treated as no key event
    always_comb begin
        next_ev_c = press_c[0] & ~press_c[1];
        prev_ev_c = press_c[1] & ~press_c[0];
        idx_inc_c = (idx_q == IDX_W'(NUM_PATTERNS - 1)) ? '0 : idx_q + IDX_W'(1);
        idx_dec_c = (idx_q == '0) ? IDX_W'(NUM_PATTERNS - 1) : idx_q - IDX_W'(1);
    end

    // Index FSM next-state: key events take priority over dwell expiry
    always_comb begin
        state_d = MODE ? ST_AUTO : ST_MANUAL;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_MANUAL: begin
                dwell_d = '0;
                if (next_ev_c)      idx_d = idx_inc_c;
                else if (prev_ev_c) idx_d = idx_dec_c;
            end
            ST_AUTO: begin
                if (next_ev_c || prev_ev_c) begin
                    dwell_d = '0;
                    idx_d   = next_ev_c ? idx_inc_c : idx_dec_c;
                end else if (tick_c) begin
                    if (dwell_q == DWELL_W'(DWELL_MS - 1)) begin
                        dwell_d = '0;
                        idx_d   = idx_inc_c;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_MANUAL;
            end
        endcase
    end

    // Index FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_MANUAL;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

    // Pattern select by index (indices beyond NUM_PATTERNS-1 are never reached)
    always_comb begin
        pat_sel_c = '0;
        for (int p = 0; p < int'(NUM_PATTERNS); p++) begin
            if (idx_q == IDX_W'(p)) pat_sel_c = PATTERNS[p*PAT_W +: PAT_W];
        end
    end

    // Segment decode with optional leading-zero blanking; digit 0 always shows
    always_comb begin
        hex_d   = '1;
        digit_c = '0;
        lead_c  = 1'b1;
        for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
            digit_c = pat_sel_c[d*4 +: 4];
            if (LZ_BLANK && lead_c && (digit_c == 4'h0) && (d != 0)) begin
                hex_d[d*8 +: 8] = 8'hFF;
            end else begin
                hex_d[d*8 +: 8] = seg7(digit_c);
                if (digit_c != 4'h0) lead_c = 1'b0;
            end
        end
    end

    // Timebase, key synchronisers, debounce state and display registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt_q <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            db_q       <= '1;
            db_cnt_q   <= '0;
            hex_q      <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= KEY;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            hex_q      <= hex_d;
        end
    end

    assign HEX     = hex_q;
    assign PAT_IDX = idx_q;

endmodule

// File: tb/tb_hex_pattern_sequencer.sv
// Directed bench for hex_pattern_sequencer: one instance without and one with leading-zero blanking.
module tb_hex_pattern_sequencer;

    localparam logic [47:0] PAT_A    = {24'h080700, 24'h030200};
    localparam logic [47:0] HEX_P0   = 48'hC0B0C0A4C0C0;
    localparam logic [47:0] HEX_P1   = 48'hC080C0F8C0C0;
    localparam logic [47:0] HEX_BLNK = 48'hFFFFFFFFFFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  key_a = 2'b11;
    logic        mode_a = 1'b0;
    logic [47:0] hex_a;
    logic        idx_a;
    logic [1:0]  key_b = 2'b11;
    logic        mode_b = 1'b0;
    logic [47:0] pat_b = {24'h000000, 24'h000042};
    logic [47:0] hex_b;
    logic        idx_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    hex_pattern_sequencer #(
        .NUM_DIGITS(6), .NUM_PATTERNS(2), .CLK_HZ(1000),
        .DWELL_MS(8), .DEBOUNCE_MS(4), .LZ_BLANK(1'b0)
    ) u_dut_a (
        .CLK(CLK), .RST(RST), .KEY(key_a), .MODE(mode_a),
        .PATTERNS(PAT_A), .HEX(hex_a), .PAT_IDX(idx_a)
    );

    hex_pattern_sequencer #(
        .NUM_DIGITS(6), .NUM_PATTERNS(2), .CLK_HZ(1000),
        .DWELL_MS(8), .DEBOUNCE_MS(4), .LZ_BLANK(1'b1)
    ) u_dut_b (
        .CLK(CLK), .RST(RST), .KEY(key_b), .MODE(mode_b),
        .PATTERNS(pat_b), .HEX(hex_b), .PAT_IDX(idx_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for 3 cycles: blank display, index 0
        cyc(3);
        check("rst_hex_a", hex_a, HEX_BLNK);
        check("rst_idx_a", 48'(idx_a), 48'd0);
        check("rst_hex_b", hex_b, HEX_BLNK);
        RST = 1'b0;
        #1;
        check("rst_fall_hex_a", hex_a, HEX_BLNK);
        cyc(1);
        check("first_edge_hex_a", hex_a, HEX_P0);

        // Leading-zero blanking on the second instance
        check("lz_0x42", hex_b, 48'hFFFFFFFF99A4);
        check("lz_idx_b", 48'(idx_b), 48'd0);
        pat_b[23:0] = 24'h000402;
        cyc(1);
        check("lz_inner_zero", hex_b, 48'hFFFFFF99C0A4);
        pat_b[23:0] = 24'h000000;
        cyc(1);
        check("lz_all_zero", hex_b, 48'hFFFFFFFFFFC0);

        // Two-cycle glitch on KEY[0]: no event
        key_a = 2'b10;
        cyc(2);
        key_a = 2'b11;
        cyc(10);
        check("glitch_idx", 48'(idx_a), 48'd0);
        check("glitch_hex", hex_a, HEX_P0);

        // Steady KEY[0]: 2 sync stages + 4 debounce ticks -> index changes on the 6th edge
        key_a = 2'b10;
        cyc(5);
        check("next_not_yet", 48'(idx_a), 48'd0);
        cyc(1);
        check("next_idx", 48'(idx_a), 48'd1);
        check("next_hex_lag", hex_a, HEX_P0);
        cyc(1);
        check("next_hex", hex_a, HEX_P1);
        cyc(20);
        check("hold_no_repeat", 48'(idx_a), 48'd1);
        key_a = 2'b11;
        cyc(8);
        check("release_no_event", 48'(idx_a), 48'd1);
        key_a = 2'b01;
        cyc(6);
        check("prev_idx", 48'(idx_a), 48'd0);
        key_a = 2'b11;
        cyc(8);

        // Wrap in both directions
        key_a = 2'b01;
        cyc(6);
        check("prev_wrap", 48'(idx_a), 48'd1);
        key_a = 2'b11;
        cyc(8);
        key_a = 2'b10;
        cyc(6);
        check("next_wrap", 48'(idx_a), 48'd0);
        key_a = 2'b11;
        cyc(8);

        // Both keys together cancel
        key_a = 2'b00;
        cyc(12);
        check("both_idx", 48'(idx_a), 48'd0);
        check("both_hex", hex_a, HEX_P0);
        key_a = 2'b11;
        cyc(8);

        // Auto rotate: state enters AUTO on edge 1, dwell ticks on edges 2..9, advance on edge 9
        mode_a = 1'b1;
        cyc(8);
        check("auto_not_yet", 48'(idx_a), 48'd0);
        cyc(1);
        check("auto_adv1", 48'(idx_a), 48'd1);
        cyc(1);
        check("auto_hex1", hex_a, HEX_P1);
        cyc(6);
        check("auto_pre_wrap", 48'(idx_a), 48'd1);
        // KEY[0] pressed now; its event lands 6 edges later, 5 ticks after the wrap below
        key_a = 2'b10;
        cyc(1);
        check("auto_wrap", 48'(idx_a), 48'd0);
        cyc(4);
        check("auto_before_key", 48'(idx_a), 48'd0);
        cyc(1);
        check("auto_key_event", 48'(idx_a), 48'd1);
        cyc(7);
        check("auto_dwell_restart", 48'(idx_a), 48'd1);
        cyc(1);
        check("auto_adv_after_key", 48'(idx_a), 48'd0);
        cyc(8);
        check("auto_adv_held_key", 48'(idx_a), 48'd1);

        // Reset mid-operation with KEY[0] held
        RST = 1'b1;
        #1;
        check("midrst_hex", hex_a, HEX_BLNK);
        check("midrst_idx", 48'(idx_a), 48'd0);
        cyc(3);
        RST = 1'b0;
        cyc(5);
        check("postrst_not_yet", 48'(idx_a), 48'd0);
        check("postrst_hex", hex_a, HEX_P0);
        cyc(1);
        check("postrst_event", 48'(idx_a), 48'd1);
        cyc(6);
        check("postrst_single", 48'(idx_a), 48'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
